// File: rtl/activation_sequencer_pkg.sv
// Shared definitions for the activation sequencer slice.
// Contents: activation function encodings, sequencer state enum, default
// address widths and matching address typedefs.
package activation_sequencer_pkg;

    // Activation function select shared with the activation datapath.
    typedef logic [1:0] ACTIVATION_BIT_TYPE;

    localparam ACTIVATION_BIT_TYPE NO_ACTIVATION = 2'b00;
    localparam ACTIVATION_BIT_TYPE RELU          = 2'b01;
    localparam ACTIVATION_BIT_TYPE SIGMOID       = 2'b10;

    // Default widths of the accumulator and unified-buffer address spaces.
    localparam int ACC_ADDR_WIDTH_DEFAULT = 9;
    localparam int BUF_ADDR_WIDTH_DEFAULT = 24;

    typedef logic [ACC_ADDR_WIDTH_DEFAULT-1:0] acc_addr_t;
    typedef logic [BUF_ADDR_WIDTH_DEFAULT-1:0] buf_addr_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/activation_sequencer_delay_line.sv
// sequencer_delay_line: DEPTH-stage shift register of {valid, address} that
// carries issued buffer rows to the write port after the pipeline latency.
// Latency: exactly DEPTH cycles. No backpressure: one entry shifts per cycle.
// Ports: clk, rst (async, active high), in_valid/in_address (stage input),
//        out_valid/out_address (last stage).
module sequencer_delay_line #(
    parameter int DEPTH      = 5,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_address,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_address
);

    logic [DEPTH-1:0]      vld;
    logic [ADDR_WIDTH-1:0] addr [DEPTH];

    // Addresses only advance with a valid entry behind them, so the final
    // stage keeps presenting the last written address while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr[k] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                addr[0] <= in_address;
            end
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    addr[k] <= addr[k-1];
                end
            end
        end
    end

    assign out_valid   = vld[DEPTH-1];
    assign out_address = addr[DEPTH-1];

endmodule

// File: rtl/activation_sequencer.sv
// activation_sequencer: accepts one activation instruction, streams
// accumulator reads, presents activation function/signedness and emits
// unified-buffer writes aligned to the accumulator+activation latency.
// Backpressure: instr_ready is high only in IDLE; one instruction at a time.
// Ports: instr_* (dispatcher handshake and fields), acc_read_* (accumulator),
//        activation_function/signed_not_unsigned (activation unit),
//        buf_write_* (unified buffer), busy/done (status).
// Optional: define ACTIVATION_SEQUENCER_PERF_EN to add saturating
//        perf_rows_written and perf_busy_cycles counters.
module activation_sequencer
    import activation_sequencer_pkg::*;
#(
    parameter int ACC_ADDR_WIDTH     = 9,
    parameter int BUF_ADDR_WIDTH     = 24,
    parameter int LENGTH_WIDTH       = 16,
    parameter int ACC_READ_LATENCY   = 2,
    parameter int ACTIVATION_LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_address,
    input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_address,
    input  logic [LENGTH_WIDTH-1:0]   instr_length,
    input  ACTIVATION_BIT_TYPE        instr_activation_function,
    input  logic                      instr_signed_not_unsigned,
    output logic                      acc_read_enable,
    output logic [ACC_ADDR_WIDTH-1:0] acc_read_address,
    output ACTIVATION_BIT_TYPE        activation_function,
    output logic                      signed_not_unsigned,
    output logic                      buf_write_enable,
    output logic [BUF_ADDR_WIDTH-1:0] buf_write_address,
    output logic                      busy,
`ifdef ACTIVATION_SEQUENCER_PERF_EN
    output logic [31:0]               perf_rows_written,
    output logic [31:0]               perf_busy_cycles,
`endif
    output logic                      done
);

    // Cycles from a read strobe to the matching activation output byte vector.
    localparam int L       = ACC_READ_LATENCY + ACTIVATION_LATENCY;
    localparam int DRAIN_W = $clog2(L + 1);

    seq_state_t                state, state_nxt;
    logic [LENGTH_WIDTH-1:0]   len_q, len_nxt;
    logic [LENGTH_WIDTH-1:0]   row_idx, row_idx_nxt;
    logic [DRAIN_W-1:0]        drain_cnt, drain_cnt_nxt;
    logic [ACC_ADDR_WIDTH-1:0] acc_ptr_nxt;
    logic [BUF_ADDR_WIDTH-1:0] buf_ptr, buf_ptr_nxt;
    ACTIVATION_BIT_TYPE        func_nxt;
    logic                      sign_nxt;
    logic                      done_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            len_q               <= '0;
            row_idx             <= '0;
            drain_cnt           <= '0;
            acc_read_address    <= '0;
            buf_ptr             <= '0;
            activation_function <= NO_ACTIVATION;
            signed_not_unsigned <= 1'b0;
            done                <= 1'b0;
        end else begin
            state               <= state_nxt;
            len_q               <= len_nxt;
            row_idx             <= row_idx_nxt;
            drain_cnt           <= drain_cnt_nxt;
            acc_read_address    <= acc_ptr_nxt;
            buf_ptr             <= buf_ptr_nxt;
            activation_function <= func_nxt;
            signed_not_unsigned <= sign_nxt;
            done                <= done_nxt;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        row_idx_nxt   = row_idx;
        drain_cnt_nxt = drain_cnt;
        acc_ptr_nxt   = acc_read_address;
        buf_ptr_nxt   = buf_ptr;
        func_nxt      = activation_function;
        sign_nxt      = signed_not_unsigned;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (instr_valid) begin
                    func_nxt      = instr_activation_function;
                    sign_nxt      = instr_signed_not_unsigned;
                    len_nxt       = instr_length;
                    row_idx_nxt   = '0;
                    drain_cnt_nxt = '0;
                    if (instr_length == '0) begin
                        // Empty instruction: complete immediately, leave the
                        // address outputs holding their previous values.
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt   = ISSUE;
                        acc_ptr_nxt = instr_acc_address;
                        buf_ptr_nxt = instr_buf_address;
                    end
                end
            end

            ISSUE: begin
                if (row_idx == len_q - LENGTH_WIDTH'(1)) begin
                    // Last row: pointers stay on it so the read address holds.
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end else begin
                    row_idx_nxt = row_idx + LENGTH_WIDTH'(1);
                    acc_ptr_nxt = acc_read_address + ACC_ADDR_WIDTH'(1);
                    buf_ptr_nxt = buf_ptr + BUF_ADDR_WIDTH'(1);
                end
            end

            DRAIN: begin
                // Wait out the pipeline so done coincides with the last write
                // having been presented on the previous cycle.
                if (drain_cnt == DRAIN_W'(L - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign acc_read_enable = (state == ISSUE);
    assign busy            = (state != IDLE);
    assign instr_ready     = (state == IDLE) && !rst;

    // Each issued row's buffer address travels alongside the data latency.
    sequencer_delay_line #(
        .DEPTH      (L),
        .ADDR_WIDTH (BUF_ADDR_WIDTH)
    ) u_delay_line (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (acc_read_enable),
        .in_address  (buf_ptr),
        .out_valid   (buf_write_enable),
        .out_address (buf_write_address)
    );

`ifdef ACTIVATION_SEQUENCER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rows_written <= '0;
            perf_busy_cycles  <= '0;
        end else begin
            if (buf_write_enable && (perf_rows_written != '1)) begin
                perf_rows_written <= perf_rows_written + 32'd1;
            end
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
